// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: CPU strobe side and asynchronous SRAM pad side of the sequencer
interface mem_access_sequencer_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Data_to_CPU;
  logic        Busy;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic [15:0] SRAM_DQ_in;
  modport master (
    output Mem_OE, Mem_WE, MAR, MDR, SRAM_DQ_in,
    input  Data_to_CPU, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
           SRAM_UB_N, SRAM_LB_N, SRAM_DQ_out, SRAM_DQ_oe
  );
  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR, SRAM_DQ_in,
    output Data_to_CPU, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
           SRAM_UB_N, SRAM_LB_N, SRAM_DQ_out, SRAM_DQ_oe
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: turns FSM memory strobes into one timed SRAM or memory-mapped I/O access
module mem_access_sequencer #(
  parameter int          ACCESS_CYCLES = 1,
  parameter logic [15:0] IO_ADDR       = 16'hFFFF,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  mem_access_sequencer_if.slave   bus,
  input  logic [15:0]             Switches,
  output logic                    Err_conflict,
  output logic [15:0]             HEX_Data
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] WR_REC = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        io_q, io_d;
  logic        err_q, err_d;
  logic [15:0] sync_q [SYNC_STAGES];
  logic        req, last, mem_rd, mem_wr, mem_rec;

  assign req  = bus.Mem_OE | bus.Mem_WE;
  assign last = cnt_q == 4'd0;

  // Access sequencing: capture once in IDLE, count the strobe window, park in HOLD until strobes drop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    io_d    = io_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = bus.Mem_WE ? WR : RD;
        cnt_d   = CNT_LOAD;
        addr_d  = bus.MAR;
        wdata_d = bus.MDR;
        io_d    = bus.MAR == IO_ADDR;
        err_d   = err_q | (bus.Mem_OE & bus.Mem_WE);
      end
      RD: begin
        rdata_d = last ? (io_q ? sync_q[SYNC_STAGES-1] : bus.SRAM_DQ_in) : rdata_q;
        state_d = last ? HOLD : RD;
        cnt_d   = last ? cnt_q : cnt_q - 4'd1;
      end
      WR: begin
        hex_d   = (io_q && cnt_q == CNT_LOAD) ? wdata_q : hex_q;
        state_d = last ? WR_REC : WR;
        cnt_d   = last ? cnt_q : cnt_q - 4'd1;
      end
      WR_REC: state_d = HOLD;
      HOLD:   state_d = req ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-access registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
      io_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      io_q    <= io_d;
      err_q   <= err_d;
    end
  end

  // Switch synchroniser chain
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= Switches;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign mem_rd  = state_q == RD     && !io_q;
  assign mem_wr  = state_q == WR     && !io_q;
  assign mem_rec = state_q == WR_REC && !io_q;

  assign bus.Busy        = state_q != IDLE;
  assign bus.Data_to_CPU = rdata_q;
  assign bus.SRAM_ADDR   = {4'h0, addr_q};
  assign bus.SRAM_CE_N   = !(mem_rd | mem_wr | mem_rec);
  assign bus.SRAM_OE_N   = !mem_rd;
  assign bus.SRAM_WE_N   = !mem_wr;
  assign bus.SRAM_UB_N   = !(mem_rd | mem_wr | mem_rec);
  assign bus.SRAM_LB_N   = !(mem_rd | mem_wr | mem_rec);
  assign bus.SRAM_DQ_out = wdata_q;
  assign bus.SRAM_DQ_oe  = mem_wr | mem_rec;
  assign Err_conflict    = err_q;
  assign HEX_Data        = hex_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: randomized scoreboard bench with an SRAM pad model and a behavioural reference
module tb_mem_access_sequencer;
  localparam int AC  = 1;
  localparam int AC4 = 4;

  logic        Clk = 1'b0;
  logic        Reset, rst4;
  logic [15:0] Switches;
  logic        Err, Err4;
  logic [15:0] HEX, HEX4;

  mem_access_sequencer_if b();
  mem_access_sequencer_if b4();

  mem_access_sequencer #(.ACCESS_CYCLES(AC)) dut (
    .Clk(Clk), .Reset(Reset), .bus(b), .Switches(Switches), .Err_conflict(Err), .HEX_Data(HEX)
  );
  mem_access_sequencer #(.ACCESS_CYCLES(AC4)) dut4 (
    .Clk(Clk), .Reset(rst4), .bus(b4), .Switches(Switches), .Err_conflict(Err4), .HEX_Data(HEX4)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          io;
    logic [15:0] data;
    logic [15:0] hex;
    bit          err;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] ref_mem [0:255];
  logic [15:0] ref_hex = 16'h0;
  logic [15:0] last_rd = 16'h0;
  bit          ref_err = 1'b0;

  logic [15:0] sram [0:255];
  bit   [255:0] sv;
  int          we4_cnt = 0;

  always @(posedge Clk) begin
    if (!b.SRAM_CE_N && !b.SRAM_WE_N && b.SRAM_DQ_oe) begin
      sram[b.SRAM_ADDR[7:0]] <= b.SRAM_DQ_out;
      sv[b.SRAM_ADDR[7:0]]   <= 1'b1;
    end
  end

  always @(negedge Clk) b.SRAM_DQ_in = sv[b.SRAM_ADDR[7:0]] ? sram[b.SRAM_ADDR[7:0]] : 16'h0;

  always @(posedge Clk) if (!b4.SRAM_WE_N) we4_cnt <= we4_cnt + 1;

  initial begin
    bit   pb;
    int   oe_c, we_c, ce_c;
    exp_t e;
    pb = 0; oe_c = 0; we_c = 0; ce_c = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        pb = 0; oe_c = 0; we_c = 0; ce_c = 0;
      end else begin
        check("oe_we_overlap", 32'(!b.SRAM_OE_N && !b.SRAM_WE_N), 32'd0);
        check("dq_oe_in_read", 32'(!b.SRAM_OE_N && b.SRAM_DQ_oe), 32'd0);
        if (b.Busy) begin
          oe_c += 32'(!b.SRAM_OE_N);
          we_c += 32'(!b.SRAM_WE_N);
          ce_c += 32'(!b.SRAM_CE_N);
        end
        if (pb && !b.Busy) begin
          if (sbq.size() == 0) check("unexpected_access", 32'd1, 32'd0);
          else begin
            e = sbq.pop_front();
            check("sb_data", 32'(b.Data_to_CPU), 32'(e.data));
            check("sb_hex", 32'(HEX), 32'(e.hex));
            check("sb_err", 32'(Err), 32'(e.err));
            check("sb_oe_cycles", 32'(oe_c), 32'((!e.wr && !e.io) ? AC : 0));
            check("sb_we_cycles", 32'(we_c), 32'((e.wr && !e.io) ? AC : 0));
            check("sb_ce_cycles", 32'(ce_c), 32'(e.io ? 0 : (e.wr ? AC + 1 : AC)));
          end
          oe_c = 0; we_c = 0; ce_c = 0;
        end
        pb = b.Busy;
      end
    end
  end

  task automatic set_sw(input logic [15:0] v);
    Switches = v;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic txn(input bit oe, input bit we, input logic [15:0] mar, input logic [15:0] mdr, input int hold);
    bit   io;
    int   h0, cid;
    exp_t e;
    io  = mar == 16'hFFFF;
    h0  = we ? AC + 2 : AC + 1;
    cid = (hold > h0 ? hold : h0) + 1;
    @(posedge Clk); #1;
    b.Mem_OE = oe; b.Mem_WE = we; b.MAR = mar; b.MDR = mdr;
    if (oe && we) ref_err = 1'b1;
    if (we) begin
      if (io) ref_hex = mdr;
      else ref_mem[mar[7:0]] = mdr;
    end else last_rd = io ? Switches : ref_mem[mar[7:0]];
    e.wr = we; e.io = io; e.data = last_rd; e.hex = ref_hex; e.err = ref_err;
    sbq.push_back(e);
    @(negedge Clk);
    check("idle_at_capture", 32'(b.Busy), 32'd0);
    for (int c = 1; c <= cid; c++) begin
      @(posedge Clk); #1;
      if (c >= hold) begin
        b.Mem_OE = 1'b0; b.Mem_WE = 1'b0;
      end else begin
        b.MAR = 16'($urandom); b.MDR = 16'($urandom);
      end
      @(negedge Clk);
      if (!io && c <= AC) begin
        check("addr", 32'(b.SRAM_ADDR), 32'({4'h0, mar}));
        check("ce_n", 32'(b.SRAM_CE_N), 32'd0);
        check("oe_n", 32'(b.SRAM_OE_N), 32'(we));
        check("we_n", 32'(b.SRAM_WE_N), 32'(!we));
        check("dq_oe", 32'(b.SRAM_DQ_oe), 32'(we));
        if (we) check("dq_out", 32'(b.SRAM_DQ_out), 32'(mdr));
      end
      if (!io && we && c == AC + 1) begin
        check("rec_we_n", 32'(b.SRAM_WE_N), 32'd1);
        check("rec_ce_n", 32'(b.SRAM_CE_N), 32'd0);
        check("rec_dq_oe", 32'(b.SRAM_DQ_oe), 32'd1);
        check("rec_dq_out", 32'(b.SRAM_DQ_out), 32'(mdr));
      end
      if (io) check("io_ce_n", 32'(b.SRAM_CE_N), 32'd1);
      if (io && we && c >= 2) check("io_hex", 32'(HEX), 32'(mdr));
      if (!we && c == AC + 1) check("rd_data_time", 32'(b.Data_to_CPU), 32'(last_rd));
      check("busy", 32'(b.Busy), 32'(c < cid));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    Reset = 1'b1; rst4 = 1'b1; Switches = 16'h00A5;
    b.Mem_OE = 1'b0; b.Mem_WE = 1'b0; b.MAR = 16'h0; b.MDR = 16'h0;
    b4.Mem_OE = 1'b0; b4.Mem_WE = 1'b0; b4.MAR = 16'h0; b4.MDR = 16'h0; b4.SRAM_DQ_in = 16'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_ce_n", 32'(b.SRAM_CE_N), 32'd1);
    check("rst_oe_n", 32'(b.SRAM_OE_N), 32'd1);
    check("rst_we_n", 32'(b.SRAM_WE_N), 32'd1);
    check("rst_ub_lb", 32'({b.SRAM_UB_N, b.SRAM_LB_N}), 32'd3);
    check("rst_dq_oe", 32'(b.SRAM_DQ_oe), 32'd0);
    check("rst_data", 32'(b.Data_to_CPU), 32'd0);
    check("rst_hex", 32'(HEX), 32'd0);
    check("rst_busy", 32'(b.Busy), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_addr", 32'(b.SRAM_ADDR), 32'd0);
    check("rst_dq_out", 32'(b.SRAM_DQ_out), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0; rst4 = 1'b0;
    set_sw(16'h00A5);
    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 3);
    txn(1'b0, 1'b1, 16'h0005, 16'h1234, 2);
    txn(1'b1, 1'b0, 16'h0005, 16'h0000, 3);
    txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, 3);
    txn(1'b0, 1'b1, 16'hFFFF, 16'h0042, 3);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1);
    txn(1'b1, 1'b1, 16'h0020, 16'h5555, 3);
    check("err_sticky", 32'(Err), 32'd1);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 10);
    for (int n = 0; n < 150; n++) begin
      int k;
      bit io;
      k  = $urandom_range(0, 9);
      io = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 7) == 0) set_sw(16'($urandom));
      txn(k < 4 || k == 9, k >= 4, io ? 16'hFFFF : 16'($urandom_range(0, 31)), 16'($urandom),
          $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end
    @(posedge Clk); #1;
    base = we4_cnt;
    b4.Mem_WE = 1'b1; b4.MAR = 16'h0100; b4.MDR = 16'h1111;
    @(posedge Clk); #1;
    b4.Mem_WE = 1'b0;
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    check("ac4_we_len", 32'(we4_cnt - base), 32'd4);
    check("ac4_idle", 32'(b4.Busy), 32'd0);
    @(posedge Clk); #1;
    b4.Mem_WE = 1'b1; b4.MAR = 16'h0100; b4.MDR = 16'h2222;
    @(posedge Clk); #1;
    rst4 = 1'b1; b4.Mem_WE = 1'b0;
    @(negedge Clk);
    check("abort_we_active", 32'(b4.SRAM_WE_N), 32'd0);
    @(negedge Clk);
    check("abort_we_n", 32'(b4.SRAM_WE_N), 32'd1);
    check("abort_dq_oe", 32'(b4.SRAM_DQ_oe), 32'd0);
    check("abort_busy", 32'(b4.Busy), 32'd0);
    base = we4_cnt;
    @(posedge Clk); #1;
    rst4 = 1'b0;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check("abort_no_retry", 32'(we4_cnt - base), 32'd0);
    check("abort_stays_idle", 32'(b4.Busy), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("final_err_clear", 32'(Err), 32'd0);
    check("final_data_clear", 32'(b.Data_to_CPU), 32'd0);
    check("final_busy", 32'(b.Busy), 32'd0);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
